ps2_kbd_events: RTL and testbench
=================================

# ps2_kbd_events

PS/2 keyboard event decoder and queue sitting directly downstream of the `ps2kbd` byte receiver and upstream of the SoC keyboard register interface. It consumes raw set-2 scancode bytes (`code`/`strobe`/`err`), folds `E0` (extended) and `F0` (break) prefixes into single key events, and drops protocol bytes. It buffers events in a small FIFO with a valid/ready pop handshake. It optionally tracks modifier state and stamps it onto each event.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: system clock. One clock only.
- `reset_i` in 1: reset, synchronous, active-high.
- `ps2_code_i` in 8: scancode byte; valid only when `ps2_strobe_i`=1.
- `ps2_strobe_i` in 1: single-cycle byte-received pulse.
- `ps2_err_i` in 1: receiver framing/parity error pulse.
- `event_o` out 16: head event: [7:0] code, [8] break, [9] extended, [12:10] {alt,ctrl,shift}, [15:13] 0.
- `event_valid_o` out 1: FIFO non-empty.
- `event_ready_i` in 1: pop head when `event_valid_o`=1.
- `overflow_o` out 1: sticky, event dropped because FIFO full.
- `err_o` out 1: sticky, `ps2_err_i` seen.
- `clr_i` in 1: clears `overflow_o` and `err_o`.

## Operation
- Prefix FSM states: IDLE, E0, F0, E0F0.
  - Byte `E0` goes IDLE→E0. Byte `F0` goes IDLE→F0 and E0→E0F0.
  - Any other byte emits an event with break=(state∈{F0,E0F0}) and ext=(state∈{E0,E0F0}), then returns to IDLE.
  - `E0` received in F0/E0F0, or `F0` received in F0/E0F0: return to IDLE with no event.
- Ignored in IDLE (no event, no state change): `00 AA EE FA FE FF E1`. The Pause sequence therefore yields ordinary `14`/`77` events; this is accepted.
- `ps2_err_i`=1: FSM→IDLE, `err_o` set, strobe in the same cycle discarded.
- FIFO:
  - Push on emit if not full; if full, drop the event and set `overflow_o`.
  - Pop when `event_valid_o`&`event_ready_i`.
  - Simultaneous push+pop when full: both happen, count unchanged, no overflow.
  - Simultaneous push+pop when empty: the push is kept and the pop is ignored, because valid was 0.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2+1 bits.
- `event_o` is first-word fall-through (async read of head entry). Value is don't-care when `event_valid_o`=0.
- `clr_i` and a set condition in the same cycle: the set wins.

## Timing
- Reset values: `event_valid_o`=0, `overflow_o`=0, `err_o`=0, `event_o`=0x0000. FSM=IDLE, pointers/count=0, modifiers=0.
- Final byte strobe in cycle N: event written at the end of N, and `event_valid_o`=1 in N+1 if the FIFO was empty.
- Pop in cycle N: next entry (or valid=0) presented in N+1.
- Sticky flags rise in the cycle after the causing event.
- Reset mid-sequence (e.g. after `E0 F0`) discards the prefix state and all queued events.
- Throughput: one event per cycle in, one event per cycle out.

## Configuration
- Macro `PS2_KBD_MODIFIERS_EN`.
- With the macro: six internal bits track left/right shift (`12`,`59`), ctrl (`14`, `E0 14`) and alt (`11`, `E0 11`).
  - Make sets the bit; break clears it.
  - `event_o[12:10]` = {lalt|ralt, lctrl|rctrl, lshift|rshift}, sampled after applying the current event.
  - Tracking updates even when the event is dropped on overflow.
- Without the macro: no modifier registers, and `event_o[12:10]`=0.

## Test plan
- Byte `1C` → one event `0x001C`, valid one cycle after the strobe; pop → `event_valid_o`=0 next cycle.
- Bytes `E0 F0 75` → single event `0x0375`. Bytes `F0 1C` → `0x011C`. Bytes `AA FA` → no events.
- Bytes `E0`, then a `ps2_err_i` pulse, then `1C` → event `0x001C` (not extended) and `err_o`=1. `clr_i` → `err_o`=0.
- With `event_ready_i`=0, push FIFO_DEPTH+1 make codes → exactly FIFO_DEPTH events and `overflow_o`=1. Draining returns them in order.
- Full FIFO, push and pop in the same cycle → count stays FIFO_DEPTH and `overflow_o` stays 0.
- `PS2_KBD_MODIFIERS_EN` defined: `12 1C F0 12 1C` → `0x041C` then `0x001C`.
  - `E0 14 21` → the `21` event reads `0x0821`.
  - Not defined: `12 1C` gives `1C` event `0x001C`.

Source files
------------

// File: rtl/ps2_kbd_events.sv
// PS/2 set-2 scancode to key-event decoder with event FIFO; optional modifier stamping via `PS2_KBD_MODIFIERS_EN.
// Latency: final byte strobe in cycle N -> event visible in N+1 (FIFO first-word fall-through).
// Backpressure: event_ready_i pops the head; a full FIFO drops new events and sets sticky overflow_o.
module ps2_kbd_events #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [7:0]  ps2_code_i,
  input  logic        ps2_strobe_i,
  input  logic        ps2_err_i,
  output logic [15:0] event_o,
  output logic        event_valid_o,
  input  logic        event_ready_i,
  output logic        overflow_o,
  output logic        err_o,
  input  logic        clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   mem [FIFO_DEPTH];

  logic        is_brk, is_ext, ignored, emit, full, push, pop;
  logic [2:0]  mod_bits;
  logic [15:0] ev_word;

  assign is_brk  = (state == S_F0) || (state == S_E0F0);
  assign is_ext  = (state == S_E0) || (state == S_E0F0);
  assign ignored = ps2_code_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};

  always_comb begin
    emit = 1'b0;
    if (ps2_strobe_i && !ps2_err_i) begin
      case (state)
        S_IDLE:  emit = !(ignored || ps2_code_i == 8'hE0 || ps2_code_i == 8'hF0);
        S_E0:    emit = (ps2_code_i != 8'hF0);
        default: emit = (ps2_code_i != 8'hE0) && (ps2_code_i != 8'hF0);
      endcase
    end
  end

`ifdef PS2_KBD_MODIFIERS_EN
  // {ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic [5:0] mods, mods_nxt;

  always_comb begin
    mods_nxt = mods;
    if (emit) begin
      case (ps2_code_i)
        8'h12: if (!is_ext) mods_nxt[0] = !is_brk;
        8'h59: if (!is_ext) mods_nxt[1] = !is_brk;
        8'h14: if (is_ext) mods_nxt[3] = !is_brk; else mods_nxt[2] = !is_brk;
        8'h11: if (is_ext) mods_nxt[5] = !is_brk; else mods_nxt[4] = !is_brk;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) mods <= '0;
    else         mods <= mods_nxt;
  end

  assign mod_bits = {mods_nxt[5] | mods_nxt[4], mods_nxt[3] | mods_nxt[2], mods_nxt[1] | mods_nxt[0]};
`else
  assign mod_bits = 3'b000;
`endif

  assign ev_word       = {3'b000, mod_bits, is_ext, is_brk, ps2_code_i};
  assign full          = count[AW];
  assign event_valid_o = (count != '0);
  assign pop           = event_valid_o && event_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push          = emit && (!full || pop);
  assign event_o       = event_valid_o ? mem[rd_ptr] : 16'h0000;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_word;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (ps2_err_i) begin
        state <= S_IDLE;
      end else if (ps2_strobe_i) begin
        case (state)
          S_IDLE: begin
            if (ps2_code_i == 8'hE0)      state <= S_E0;
            else if (ps2_code_i == 8'hF0) state <= S_F0;
          end
          S_E0:    state <= (ps2_code_i == 8'hF0) ? S_E0F0 : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase

      if (emit && full && !pop) overflow_o <= 1'b1;
      else if (clr_i)           overflow_o <= 1'b0;

      if (ps2_err_i)   err_o <= 1'b1;
      else if (clr_i)  err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_events.sv
// Self-checking bench for ps2_kbd_events: vector table, corner sequences, random run vs. queue model.
module tb_ps2_kbd_events;
  localparam int D = 8;

`ifdef PS2_KBD_MODIFIERS_EN
  localparam logic [15:0] SH = 16'h0400;
  localparam logic [15:0] CT = 16'h0800;
`else
  localparam logic [15:0] SH = 16'h0000;
  localparam logic [15:0] CT = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  ps2_code_i = 8'h00;
  logic        ps2_strobe_i = 1'b0;
  logic        ps2_err_i = 1'b0;
  logic [15:0] event_o;
  logic        event_valid_o;
  logic        event_ready_i = 1'b0;
  logic        overflow_o;
  logic        err_o;
  logic        clr_i = 1'b0;

  int total = 0;
  int bad = 0;

  ps2_kbd_events #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_i(reset_i), .ps2_code_i(ps2_code_i), .ps2_strobe_i(ps2_strobe_i),
    .ps2_err_i(ps2_err_i), .event_o(event_o), .event_valid_o(event_valid_o),
    .event_ready_i(event_ready_i), .overflow_o(overflow_o), .err_o(err_o), .clr_i(clr_i)
  );

  always #5 clk = ~clk;

  // Reference model: pending-prefix flags, event queue, sticky flags, modifier keys.
  logic [15:0] mq[$];
  bit m_ext, m_brk, m_ovf, m_err;
  bit ls, rs, lc, rc, la, ra;

  function automatic bit is_ignored(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFE || b == 8'hFF || b == 8'hE1;
  endfunction

  task automatic model_update();
    bit pop, have, ovf_set, idle;
    logic [15:0] ev;
    if (reset_i) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
      {ls, rs, lc, rc, la, ra} = '0;
      return;
    end
    pop  = (mq.size() > 0) && event_ready_i;
    have = 0;
    ev   = '0;
    idle = !m_ext && !m_brk;
    if (ps2_err_i) begin
      m_ext = 0; m_brk = 0;
    end else if (ps2_strobe_i) begin
      if (ps2_code_i == 8'hE0 && idle) m_ext = 1;
      else if (ps2_code_i == 8'hF0 && !m_brk) m_brk = 1;
      else if (m_brk && (ps2_code_i == 8'hE0 || ps2_code_i == 8'hF0)) begin
        m_ext = 0; m_brk = 0;
      end else if (idle && is_ignored(ps2_code_i)) begin
      end else begin
        have = 1;
        ev = {6'b0, m_ext, m_brk, ps2_code_i};
`ifdef PS2_KBD_MODIFIERS_EN
        if (ps2_code_i == 8'h12 && !m_ext) ls = !m_brk;
        if (ps2_code_i == 8'h59 && !m_ext) rs = !m_brk;
        if (ps2_code_i == 8'h14) begin if (m_ext) rc = !m_brk; else lc = !m_brk; end
        if (ps2_code_i == 8'h11) begin if (m_ext) ra = !m_brk; else la = !m_brk; end
        ev[12:10] = {la | ra, lc | rc, ls | rs};
`endif
        m_ext = 0; m_brk = 0;
      end
    end
    ovf_set = have && mq.size() == D && !pop;
    if (pop) void'(mq.pop_front());
    if (have && mq.size() < D) mq.push_back(ev);
    if (ovf_set) m_ovf = 1; else if (clr_i) m_ovf = 0;
    if (ps2_err_i) m_err = 1; else if (clr_i) m_err = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("valid", {31'b0, event_valid_o}, {31'b0, mq.size() > 0});
    chk("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
    chk("err", {31'b0, err_o}, {31'b0, m_err});
    if (mq.size() > 0) chk("event", {16'b0, event_o}, {16'b0, mq[0]});
  endtask

  task automatic send(input logic [7:0] b);
    ps2_code_i = b; ps2_strobe_i = 1'b1;
    step();
    ps2_strobe_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; step(); reset_i = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [15:0] exp);
    chk({nm, "_v"}, {31'b0, event_valid_o}, 32'd1);
    chk(nm, {16'b0, event_o}, {16'b0, exp});
    event_ready_i = 1'b1; step(); event_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b [3];
    int          n;
    int          nev;
    logic [15:0] first;
  } vec_t;

  vec_t vt [10];
  byte  codes [14] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11, 8'h1C,
                       8'h75, 8'hAA, 8'hFA, 8'h00, 8'hE1, 8'h21, 8'hFF};

  initial begin
    vt[0] = '{'{8'h1C, 8'h00, 8'h00}, 1, 1, 16'h001C};
    vt[1] = '{'{8'hE0, 8'hF0, 8'h75}, 3, 1, 16'h0375};
    vt[2] = '{'{8'hF0, 8'h1C, 8'h00}, 2, 1, 16'h011C};
    vt[3] = '{'{8'hAA, 8'hFA, 8'h00}, 2, 0, 16'h0000};
    vt[4] = '{'{8'hE0, 8'h75, 8'h00}, 2, 1, 16'h0275};
    vt[5] = '{'{8'hF0, 8'hE0, 8'h1C}, 3, 1, 16'h001C};
    vt[6] = '{'{8'hE0, 8'hF0, 8'hF0}, 3, 0, 16'h0000};
    vt[7] = '{'{8'h12, 8'h1C, 8'h00}, 2, 2, 16'h0012 | SH};
    vt[8] = '{'{8'hE1, 8'h14, 8'h77}, 3, 2, 16'h0014 | CT};
    vt[9] = '{'{8'hF0, 8'h14, 8'h00}, 2, 1, 16'h0114};

    do_reset();
    do_reset();
    chk("rst_event", {16'b0, event_o}, 32'h0);
    chk("rst_valid", {31'b0, event_valid_o}, 32'h0);
    chk("rst_ovf", {31'b0, overflow_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);

    for (int v = 0; v < 10; v++) begin
      int seen;
      do_reset();
      for (int k = 0; k < vt[v].n; k++) send(vt[v].b[k]);
      step();
      chk($sformatf("vec%0d_valid", v), {31'b0, event_valid_o}, {31'b0, vt[v].nev > 0});
      if (vt[v].nev > 0) chk($sformatf("vec%0d_head", v), {16'b0, event_o}, {16'b0, vt[v].first});
      seen = 0;
      event_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (event_valid_o) seen++;
        step();
      end
      event_ready_i = 1'b0;
      chk($sformatf("vec%0d_count", v), seen, vt[v].nev);
    end

    // Latency: valid right after the strobe edge, gone right after the pop edge.
    do_reset();
    send(8'h1C);
    chk("lat_valid", {31'b0, event_valid_o}, 32'd1);
    pop_chk("lat_ev", 16'h001C);
    chk("lat_empty", {31'b0, event_valid_o}, 32'd0);

    // Error drops the E0 prefix.
    do_reset();
    send(8'hE0);
    ps2_err_i = 1'b1; step(); ps2_err_i = 1'b0;
    send(8'h1C);
    chk("err_set", {31'b0, err_o}, 32'd1);
    pop_chk("err_ev", 16'h001C);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    chk("err_clr", {31'b0, err_o}, 32'd0);

    // Overflow: D+1 pushes, exactly D kept in order.
    do_reset();
    for (int i = 0; i <= D; i++) send(8'h40 + 8'(i));
    chk("ovf_set", {31'b0, overflow_o}, 32'd1);
    for (int i = 0; i < D; i++) pop_chk($sformatf("ovf_ev%0d", i), 16'h0040 + 16'(i));
    chk("ovf_drained", {31'b0, event_valid_o}, 32'd0);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    chk("ovf_clr", {31'b0, overflow_o}, 32'd0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < D; i++) send(8'h20 + 8'(i));
    event_ready_i = 1'b1; send(8'h30); event_ready_i = 1'b0;
    chk("fullpp_ovf", {31'b0, overflow_o}, 32'd0);
    for (int i = 1; i < D; i++) pop_chk($sformatf("fullpp_ev%0d", i), 16'h0020 + 16'(i));
    pop_chk("fullpp_last", 16'h0030);
    chk("fullpp_empty", {31'b0, event_valid_o}, 32'd0);

    // Reset mid-prefix discards it.
    do_reset();
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h75);
    pop_chk("midrst_ev", 16'h0075);

    // Modifier stamping.
    do_reset();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    pop_chk("mod_sh_make", 16'h0012 | SH);
    pop_chk("mod_sh_1c", 16'h001C | SH);
    pop_chk("mod_sh_brk", 16'h0112);
    pop_chk("mod_plain_1c", 16'h001C);
    send(8'hE0); send(8'h14); send(8'h21);
    pop_chk("mod_rctrl", 16'h0214 | CT);
    pop_chk("mod_ctrl_21", 16'h0021 | CT);

    // Random run against the model.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int rdy_pct;
      rdy_pct = ((cyc / 250) % 2 == 0) ? 20 : 90;
      ps2_strobe_i  = ($urandom_range(0, 99) < 55);
      ps2_code_i    = codes[$urandom_range(0, 13)];
      ps2_err_i     = ($urandom_range(0, 39) == 0);
      clr_i         = ($urandom_range(0, 49) == 0);
      event_ready_i = ($urandom_range(0, 99) < rdy_pct);
      reset_i       = ($urandom_range(0, 999) == 0);
      step();
    end
    reset_i = 1'b0; ps2_strobe_i = 1'b0; ps2_err_i = 1'b0; clr_i = 1'b0; event_ready_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
